// File: rtl/ucsbece154a_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback,
// with a saturating wait-state counter gating completion of every memory access.
module ucsbece154a_mc_controller #(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    output logic       IorD_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic       RegDst_o,
    output logic       MemToReg_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ALUControl_o,
    output logic [1:0] PCSrc_o,
    output logic       PCWrite_o,
    output logic       Branch_o,
    output logic       BranchZero_o,
    output logic       ZeroExtImm_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT_CYCLES);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_mem;
    logic             w_done;

    assign w_mem   = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    assign w_done  = (r_cnt == WAIT_C) && mem_ready_i;
    assign state_o = r_state;

    // Moore decode of the current state; only the fetch strobes also see done
    always_comb begin
        w_next       = r_state;
        IorD_o       = 1'b0;
        MemWrite_o   = 1'b0;
        IRWrite_o    = 1'b0;
        RegDst_o     = 1'b0;
        MemToReg_o   = 1'b0;
        RegWrite_o   = 1'b0;
        ALUSrcA_o    = 1'b0;
        ALUSrcB_o    = 2'b00;
        ALUControl_o = 3'b000;
        PCSrc_o      = 2'b00;
        PCWrite_o    = 1'b0;
        Branch_o     = 1'b0;
        BranchZero_o = 1'b0;
        ZeroExtImm_o = 1'b0;
        illegal_o    = 1'b0;
        case (r_state)
            FETCH: begin
                ALUSrcB_o    = 2'b01;
                ALUControl_o = 3'b010;
                IRWrite_o    = w_done;
                PCWrite_o    = w_done;
                if (w_done) w_next = DECODE;
            end
            DECODE: begin
                ALUSrcB_o    = 2'b11;
                ALUControl_o = 3'b010;
                case (op_i)
                    OP_LW, OP_SW:     w_next = MEMADR;
                    OP_RTYPE:         w_next = RTYPEEX;
                    OP_BEQ, OP_BNE:   w_next = BRANCH;
                    OP_ADDI, OP_ORI:  w_next = IMMEX;
                    OP_J:             w_next = JUMP;
                    default: begin
                        illegal_o = 1'b1;
                        w_next    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA_o    = 1'b1;
                ALUSrcB_o    = 2'b10;
                ALUControl_o = 3'b010;
                w_next       = (op_i == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD_o = 1'b1;
                if (w_done) w_next = MEMWB;
            end
            MEMWB: begin
                MemToReg_o = 1'b1;
                RegWrite_o = 1'b1;
                w_next     = FETCH;
            end
            MEMWR: begin
                IorD_o     = 1'b1;
                MemWrite_o = 1'b1;
                if (w_done) w_next = FETCH;
            end
            RTYPEEX: begin
                ALUSrcA_o = 1'b1;
                w_next    = ALUWB;
                case (funct_i)
                    FN_ADD: ALUControl_o = 3'b010;
                    FN_SUB: ALUControl_o = 3'b110;
                    FN_AND: ALUControl_o = 3'b000;
                    FN_OR:  ALUControl_o = 3'b001;
                    FN_SLT: ALUControl_o = 3'b111;
                    default: begin
                        ALUControl_o = 3'b010;
                        illegal_o    = 1'b1;
                        w_next       = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                RegDst_o   = 1'b1;
                RegWrite_o = 1'b1;
                w_next     = FETCH;
            end
            BRANCH: begin
                ALUSrcA_o    = 1'b1;
                ALUControl_o = 3'b110;
                PCSrc_o      = 2'b01;
                Branch_o     = 1'b1;
                BranchZero_o = (op_i == OP_BEQ);
                w_next       = FETCH;
            end
            IMMEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                if (op_i == OP_ORI) begin
                    ALUControl_o = 3'b001;
                    ZeroExtImm_o = 1'b1;
                end else begin
                    ALUControl_o = 3'b010;
                end
                w_next = IMMWB;
            end
            IMMWB: begin
                RegWrite_o = 1'b1;
                w_next     = FETCH;
            end
            JUMP: begin
                PCSrc_o   = 2'b10;
                PCWrite_o = 1'b1;
                w_next    = FETCH;
            end
            default: w_next = FETCH;
        endcase
    end

    // Counter restarts on every transition and saturates while a memory state is held
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (w_mem && (r_cnt != WAIT_C)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ucsbece154a_mc_controller.sv
// Directed bench for the multicycle controller: per-cycle vector table on a zero-wait
// instance plus hand sequences for wait states, saturation and asynchronous reset.
module tb_ucsbece154a_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       rdy;

    // Control vector order: IorD MemWrite IRWrite RegDst MemToReg RegWrite ALUSrcA
    // ALUSrcB[1:0] ALUControl[2:0] PCSrc[1:0] PCWrite Branch BranchZero ZeroExtImm illegal
    logic       a_IorD, a_MemWrite, a_IRWrite, a_RegDst, a_MemToReg, a_RegWrite, a_ALUSrcA;
    logic [1:0] a_ALUSrcB, a_PCSrc;
    logic [2:0] a_ALUControl;
    logic       a_PCWrite, a_Branch, a_BranchZero, a_ZeroExtImm, a_illegal;
    logic [3:0] a_state;

    logic       b_IorD, b_MemWrite, b_IRWrite, b_RegDst, b_MemToReg, b_RegWrite, b_ALUSrcA;
    logic [1:0] b_ALUSrcB, b_PCSrc;
    logic [2:0] b_ALUControl;
    logic       b_PCWrite, b_Branch, b_BranchZero, b_ZeroExtImm, b_illegal;
    logic [3:0] b_state;

    logic [18:0] a_ctrl;
    assign a_ctrl = {a_IorD, a_MemWrite, a_IRWrite, a_RegDst, a_MemToReg, a_RegWrite, a_ALUSrcA,
                     a_ALUSrcB, a_ALUControl, a_PCSrc, a_PCWrite, a_Branch, a_BranchZero,
                     a_ZeroExtImm, a_illegal};

    ucsbece154a_mc_controller #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset), .op_i(op), .funct_i(funct), .mem_ready_i(rdy),
        .IorD_o(a_IorD), .MemWrite_o(a_MemWrite), .IRWrite_o(a_IRWrite), .RegDst_o(a_RegDst),
        .MemToReg_o(a_MemToReg), .RegWrite_o(a_RegWrite), .ALUSrcA_o(a_ALUSrcA),
        .ALUSrcB_o(a_ALUSrcB), .ALUControl_o(a_ALUControl), .PCSrc_o(a_PCSrc),
        .PCWrite_o(a_PCWrite), .Branch_o(a_Branch), .BranchZero_o(a_BranchZero),
        .ZeroExtImm_o(a_ZeroExtImm), .illegal_o(a_illegal), .state_o(a_state)
    );

    ucsbece154a_mc_controller #(.WAIT_CYCLES(2), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .op_i(op), .funct_i(funct), .mem_ready_i(rdy),
        .IorD_o(b_IorD), .MemWrite_o(b_MemWrite), .IRWrite_o(b_IRWrite), .RegDst_o(b_RegDst),
        .MemToReg_o(b_MemToReg), .RegWrite_o(b_RegWrite), .ALUSrcA_o(b_ALUSrcA),
        .ALUSrcB_o(b_ALUSrcB), .ALUControl_o(b_ALUControl), .PCSrc_o(b_PCSrc),
        .PCWrite_o(b_PCWrite), .Branch_o(b_Branch), .BranchZero_o(b_BranchZero),
        .ZeroExtImm_o(b_ZeroExtImm), .illegal_o(b_illegal), .state_o(b_state)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, ORI = 6'b001101, JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SLT = 6'b101010, F_BAD = 6'b000111;

    localparam logic [18:0] E_FETCH_D = {7'b0010000, 2'b01, 3'b010, 2'b00, 5'b10000};
    localparam logic [18:0] E_FETCH_W = {7'b0000000, 2'b01, 3'b010, 2'b00, 5'b00000};
    localparam logic [18:0] E_DECODE  = {7'b0000000, 2'b11, 3'b010, 2'b00, 5'b00000};
    localparam logic [18:0] E_DEC_ILL = {7'b0000000, 2'b11, 3'b010, 2'b00, 5'b00001};
    localparam logic [18:0] E_MEMADR  = {7'b0000001, 2'b10, 3'b010, 2'b00, 5'b00000};
    localparam logic [18:0] E_MEMRD   = {7'b1000000, 2'b00, 3'b000, 2'b00, 5'b00000};
    localparam logic [18:0] E_MEMWB   = {7'b0000110, 2'b00, 3'b000, 2'b00, 5'b00000};
    localparam logic [18:0] E_MEMWR   = {7'b1100000, 2'b00, 3'b000, 2'b00, 5'b00000};
    localparam logic [18:0] E_R_ADD   = {7'b0000001, 2'b00, 3'b010, 2'b00, 5'b00000};
    localparam logic [18:0] E_R_SLT   = {7'b0000001, 2'b00, 3'b111, 2'b00, 5'b00000};
    localparam logic [18:0] E_R_ILL   = {7'b0000001, 2'b00, 3'b010, 2'b00, 5'b00001};
    localparam logic [18:0] E_ALUWB   = {7'b0001010, 2'b00, 3'b000, 2'b00, 5'b00000};
    localparam logic [18:0] E_BEQ     = {7'b0000001, 2'b00, 3'b110, 2'b01, 5'b01100};
    localparam logic [18:0] E_BNE     = {7'b0000001, 2'b00, 3'b110, 2'b01, 5'b01000};
    localparam logic [18:0] E_ADDI    = {7'b0000001, 2'b10, 3'b010, 2'b00, 5'b00000};
    localparam logic [18:0] E_ORI     = {7'b0000001, 2'b10, 3'b001, 2'b00, 5'b00010};
    localparam logic [18:0] E_IMMWB   = {7'b0000010, 2'b00, 3'b000, 2'b00, 5'b00000};
    localparam logic [18:0] E_JUMP    = {7'b0000000, 2'b00, 3'b000, 2'b10, 5'b10000};

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        rdy;
        logic [3:0]  st;
        logic [18:0] ctrl;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic r,
                       input logic [3:0] s, input logic [18:0] c);
        vec_t t;
        t.op = o; t.funct = f; t.rdy = r; t.st = s; t.ctrl = c;
        vecs.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic [5:0] o, input logic [5:0] f, input logic r);
        op = o; funct = f; rdy = r;
        #1;
    endtask

    // Pulse reset entirely inside the low phase so no clock edge sees it released early
    task automatic pulse_reset();
        @(negedge clk);
        rdy = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op = LW; funct = 6'b0; rdy = 1'b0;

        add(LW, 6'b0, 1'b0, 4'd0, E_FETCH_W);
        add(LW, 6'b0, 1'b1, 4'd0, E_FETCH_D);
        add(LW, 6'b0, 1'b1, 4'd1, E_DECODE);
        add(LW, 6'b0, 1'b1, 4'd2, E_MEMADR);
        add(LW, 6'b0, 1'b1, 4'd3, E_MEMRD);
        add(LW, 6'b0, 1'b1, 4'd4, E_MEMWB);
        add(SW, 6'b0, 1'b1, 4'd0, E_FETCH_D);
        add(SW, 6'b0, 1'b1, 4'd1, E_DECODE);
        add(SW, 6'b0, 1'b1, 4'd2, E_MEMADR);
        add(SW, 6'b0, 1'b1, 4'd5, E_MEMWR);
        add(RT, F_ADD, 1'b1, 4'd0, E_FETCH_D);
        add(RT, F_ADD, 1'b1, 4'd1, E_DECODE);
        add(RT, F_ADD, 1'b1, 4'd6, E_R_ADD);
        add(RT, F_ADD, 1'b1, 4'd7, E_ALUWB);
        add(BEQ, 6'b0, 1'b1, 4'd0, E_FETCH_D);
        add(BEQ, 6'b0, 1'b1, 4'd1, E_DECODE);
        add(BEQ, 6'b0, 1'b1, 4'd8, E_BEQ);
        add(ADDI, 6'b0, 1'b1, 4'd0, E_FETCH_D);
        add(ADDI, 6'b0, 1'b1, 4'd1, E_DECODE);
        add(ADDI, 6'b0, 1'b1, 4'd9, E_ADDI);
        add(ADDI, 6'b0, 1'b1, 4'd10, E_IMMWB);
        add(JMP, 6'b0, 1'b1, 4'd0, E_FETCH_D);
        add(JMP, 6'b0, 1'b1, 4'd1, E_DECODE);
        add(JMP, 6'b0, 1'b1, 4'd11, E_JUMP);
        add(ORI, 6'b0, 1'b1, 4'd0, E_FETCH_D);
        add(ORI, 6'b0, 1'b1, 4'd1, E_DECODE);
        add(ORI, 6'b0, 1'b1, 4'd9, E_ORI);
        add(ORI, 6'b0, 1'b1, 4'd10, E_IMMWB);
        add(BNE, 6'b0, 1'b1, 4'd0, E_FETCH_D);
        add(BNE, 6'b0, 1'b1, 4'd1, E_DECODE);
        add(BNE, 6'b0, 1'b1, 4'd8, E_BNE);
        add(RT, F_SLT, 1'b1, 4'd0, E_FETCH_D);
        add(RT, F_SLT, 1'b1, 4'd1, E_DECODE);
        add(RT, F_SLT, 1'b1, 4'd6, E_R_SLT);
        add(RT, F_SLT, 1'b1, 4'd7, E_ALUWB);
        add(BAD, 6'b0, 1'b1, 4'd0, E_FETCH_D);
        add(BAD, 6'b0, 1'b1, 4'd1, E_DEC_ILL);
        add(RT, F_BAD, 1'b1, 4'd0, E_FETCH_D);
        add(RT, F_BAD, 1'b1, 4'd1, E_DECODE);
        add(RT, F_BAD, 1'b1, 4'd6, E_R_ILL);
        add(SW, 6'b0, 1'b1, 4'd0, E_FETCH_D);
        add(SW, 6'b0, 1'b1, 4'd1, E_DECODE);
        add(SW, 6'b0, 1'b1, 4'd2, E_MEMADR);
        add(SW, 6'b0, 1'b0, 4'd5, E_MEMWR);
        add(SW, 6'b0, 1'b0, 4'd5, E_MEMWR);
        add(SW, 6'b0, 1'b0, 4'd5, E_MEMWR);
        add(SW, 6'b0, 1'b1, 4'd5, E_MEMWR);
        add(LW, 6'b0, 1'b0, 4'd0, E_FETCH_W);

        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", 32'(a_state), 32'd0);
        chk("reset_memwrite", 32'(a_MemWrite), 32'd0);
        chk("reset_regwrite", 32'(a_RegWrite), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            apply(vecs[i].op, vecs[i].funct, vecs[i].rdy);
            chk($sformatf("vec%0d_state", i), 32'(a_state), 32'(vecs[i].st));
            chk($sformatf("vec%0d_ctrl", i), 32'(a_ctrl), 32'(vecs[i].ctrl));
        end

        // Asynchronous reset while a store is being held in MEMWR
        @(negedge clk); apply(SW, 6'b0, 1'b1);
        chk("ar_fetch", 32'(a_state), 32'd0);
        @(negedge clk); apply(SW, 6'b0, 1'b1);
        @(negedge clk); apply(SW, 6'b0, 1'b0);
        chk("ar_memadr", 32'(a_state), 32'd2);
        @(negedge clk); apply(SW, 6'b0, 1'b0);
        chk("ar_memwr_state", 32'(a_state), 32'd5);
        chk("ar_memwr_we", 32'(a_MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("ar_we_dropped", 32'(a_MemWrite), 32'd0);
        chk("ar_state0", 32'(a_state), 32'd0);
        chk("ar_cnt0", 32'(dut0.r_cnt), 32'd0);
        chk("ar_cnt2", 32'(dut2.r_cnt), 32'd0);
        reset = 1'b0;
        @(negedge clk); apply(SW, 6'b0, 1'b0);
        chk("ar_restart", 32'(a_state), 32'd0);

        // WAIT_CYCLES=2: early ready ignored, counter saturates while ready is low
        pulse_reset();
        op = ADDI;
        chk("w2_c1_cnt", 32'(dut2.r_cnt), 32'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk); apply(ADDI, 6'b0, 1'b0);
            chk($sformatf("w2_sat%0d_cnt", c), 32'(dut2.r_cnt), (c >= 2) ? 32'd2 : 32'(c));
            chk($sformatf("w2_sat%0d_ir", c), 32'(b_IRWrite), 32'd0);
            chk($sformatf("w2_sat%0d_st", c), 32'(b_state), 32'd0);
        end
        @(negedge clk); apply(ADDI, 6'b0, 1'b1);
        chk("w2_sat_done_ir", 32'(b_IRWrite), 32'd1);
        chk("w2_sat_done_pc", 32'(b_PCWrite), 32'd1);
        @(negedge clk); apply(ADDI, 6'b0, 1'b1);
        chk("w2_sat_decode", 32'(b_state), 32'd1);
        chk("w2_sat_cnt_clr", 32'(dut2.r_cnt), 32'd0);

        // WAIT_CYCLES=2 with ready held high: fetch completes on its third cycle
        pulse_reset();
        apply(ADDI, 6'b0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) begin
                @(negedge clk); apply(ADDI, 6'b0, 1'b1);
            end
            chk($sformatf("w2_f%0d_st", c), 32'(b_state), 32'd0);
            chk($sformatf("w2_f%0d_ir", c), 32'(b_IRWrite), (c == 3) ? 32'd1 : 32'd0);
            chk($sformatf("w2_f%0d_pc", c), 32'(b_PCWrite), (c == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk); apply(ADDI, 6'b0, 1'b1);
        chk("w2_f4_decode", 32'(b_state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ucsbece154a_mc_controller.md
Name: ucsbece154a_mc_controller

Overview:
Multicycle MIPS control unit, successor to the single-cycle controller. It sequences each instruction through fetch, decode, execute, memory and writeback states using a Moore FSM. It supports variable-latency memory through a parametrised wait-state counter and a ready handshake. It drives the multicycle datapath (IR, A/B, ALUOut, Data registers) and is instantiated by the multicycle top in place of the combinational controller.

Parameters:
WAIT_CYCLES, 0, minimum extra cycles each memory access state is held before completion is allowed (0..15).
CNT_W, 4, width of the wait-state counter; must satisfy 2^CNT_W > WAIT_CYCLES.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
op_i  input  6  opcode, IR[31:26]
funct_i  input  6  function field, IR[5:0]
mem_ready_i  input  1  memory completes the current access this cycle
IorD_o  output  1  memory address select: 0 = PC, 1 = ALUOut
MemWrite_o  output  1  memory write strobe
IRWrite_o  output  1  instruction register load
RegDst_o  output  1  write register: 0 = rt, 1 = rd
MemToReg_o  output  1  writeback source: 0 = ALUOut, 1 = Data
RegWrite_o  output  1  register file write enable
ALUSrcA_o  output  1  ALU A: 0 = PC, 1 = A register
ALUSrcB_o  output  2  ALU B: 00 = B, 01 = constant 4, 10 = imm, 11 = imm<<2
ALUControl_o  output  3  ALU operation
PCSrc_o  output  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
PCWrite_o  output  1  unconditional PC load
Branch_o  output  1  conditional PC load
BranchZero_o  output  1  1 = beq (taken on zero), 0 = bne (taken on nonzero)
ZeroExtImm_o  output  1  zero-extend immediate (ori)
illegal_o  output  1  unsupported opcode or funct decoded
state_o  output  4  current state encoding (debug)

Behaviour:
- Reset: asynchronous; state <= FETCH (0) and cnt <= 0 immediately. Outputs follow FETCH decode, so no write strobe is ever produced from a stale state.
- Counter and completion:
  - cnt clears on every state transition.
  - In memory states (FETCH, MEMRD, MEMWR), cnt increments each cycle and saturates at WAIT_CYCLES.
  - done = (cnt == WAIT_CYCLES) && mem_ready_i.
  - A memory state holds until done. Outside memory states, done is ignored.
- States, encodings, outputs (unlisted outputs are 0):
  - FETCH=0: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00; IRWrite=done, PCWrite=done. Goes to DECODE on done.
  - DECODE=1: ALUSrcA=0, ALUSrcB=11, ALUControl=010. Next state by op:
    - lw(100011) or sw(101011) -> MEMADR
    - R(000000) -> RTYPEEX
    - beq(000100) or bne(000101) -> BRANCH
    - addi(001000) or ori(001101) -> IMMEX
    - j(000010) -> JUMP
    - any other op: illegal_o=1 this cycle, -> FETCH
  - MEMADR=2: ALUSrcA=1, ALUSrcB=10, ALUControl=010. -> MEMRD if lw, MEMWR if sw.
  - MEMRD=3: IorD=1. -> MEMWB on done.
  - MEMWB=4: RegDst=0, MemToReg=1, RegWrite=1. -> FETCH.
  - MEMWR=5: IorD=1, MemWrite=1 held for every cycle in the state. -> FETCH on done.
  - RTYPEEX=6: ALUSrcA=1, ALUSrcB=00, ALUControl from funct:
    - add 100000 -> 010; sub 100010 -> 110; and 100100 -> 000; or 100101 -> 001; slt 101010 -> 111
    - other funct: ALUControl=010, illegal_o=1, -> FETCH without writeback
    - legal funct -> ALUWB
  - ALUWB=7: RegDst=1, RegWrite=1. -> FETCH.
  - BRANCH=8: ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1, BranchZero=(op==beq). -> FETCH.
  - IMMEX=9: ALUSrcA=1, ALUSrcB=10. addi: ALUControl=010, ZeroExtImm=0. ori: ALUControl=001, ZeroExtImm=1. -> IMMWB.
  - IMMWB=10: RegDst=0, RegWrite=1. -> FETCH.
  - JUMP=11: PCSrc=10, PCWrite=1. -> FETCH.
  - Encodings 12-15 unreachable; if entered, all outputs 0 and next state = FETCH.
- Latency with WAIT_CYCLES=0 and mem_ready_i=1: lw 5 cycles; sw, R-type, addi, ori 4; beq, bne, j 3. Each memory state adds WAIT_CYCLES plus any cycles with ready low.
- mem_ready_i is ignored before the counter reaches WAIT_CYCLES; an early ready does not complete the access.
- Reset asserted mid-access (e.g. in MEMWR): MemWrite_o drops asynchronously, FSM restarts at FETCH.

Test Plan:
- WAIT_CYCLES=0, ready tied 1, sequence lw/sw/add/beq/addi/j -> state_o traces 0,1,2,3,4 / 0,1,2,5 / 0,1,6,7 / 0,1,8 / 0,1,9,10 / 0,1,11; cycle counts 5/4/4/3/4/3.
- WAIT_CYCLES=2, ready held 1 -> FETCH lasts 3 cycles; IRWrite_o and PCWrite_o high only in the third cycle.
- WAIT_CYCLES=0, sw with ready low for 3 cycles -> MEMWR held 4 cycles, MemWrite_o high in all 4, then FETCH.
- Decode checks: ori -> ALUControl_o=001 and ZeroExtImm_o=1 in IMMEX; bne -> BranchZero_o=0 and Branch_o=1 in BRANCH; funct slt -> ALUControl_o=111.
- Illegal op 111111 -> illegal_o=1 in DECODE, next state FETCH, no RegWrite/MemWrite. R-type funct 000111 -> illegal_o=1 in RTYPEEX, no ALUWB.
- Reset pulse asserted asynchronously while in MEMWR -> MemWrite_o=0 before the next clock edge, state_o=0, cnt=0.
